// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA
   } state_e;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   localparam int PAYLOAD_W = 10;

endpackage

// File: rtl/spi_tx_shift.sv
// Parallel-load shift register that serialises the RAM read byte onto MISO, MSB first.
// The MSB goes straight to the registered MISO bit on load; remaining bits follow one per shift.
module spi_tx_shift #(
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              miso_o
);

   logic [DATA_W-1:0] shift_q, shift_d;
   logic              miso_q, miso_d;

   // Next-state selection: clear wins over load, load wins over shift; zeros are shifted in behind the data
   always_comb begin
      shift_d = shift_q;
      miso_d  = miso_q;
      if (clear_i) begin
         shift_d = '0;
         miso_d  = 1'b0;
      end else if (load_i) begin
         shift_d = {data_i[DATA_W-2:0], 1'b0};
         miso_d  = data_i[DATA_W-1];
      end else if (shift_i) begin
         shift_d = {shift_q[DATA_W-2:0], 1'b0};
         miso_d  = shift_q[DATA_W-1];
      end
   end

   // Register the shifter and the MISO bit so MISO only changes after a clock edge
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shift_q <= '0;
         miso_q  <= 1'b0;
      end else begin
         shift_q <= shift_d;
         miso_q  <= miso_d;
      end
   end

   assign miso_o = miso_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end: frames MOSI words under SS_n, forwards them to the RAM, and returns read bytes on MISO.
module spi_slave
   import spi_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic [DATA_W+1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid
);

   localparam int PW = DATA_W + 2;

   state_e          state_q;
   logic [3:0]      count_q;
   logic [PW-2:0]   payload_q;
   logic [PW-1:0]   rxData_q;
   logic            rxValid_q;
   logic            rdAddrSeen_q;
   logic            payloadDone_q;
   logic            loaded_q;
   logic            txDone_q;

   logic            loadEn;
   logic            shiftEn;

   // Read-byte handshake: take the RAM byte once per frame, then clock it out one bit per cycle
   always_comb begin
      loadEn  = (state_q == READ_DATA) && !SS_n && payloadDone_q && !loaded_q && tx_valid;
      shiftEn = (state_q == READ_DATA) && !SS_n && loaded_q && !txDone_q;
   end

   // Frame FSM: selector decode, payload assembly, rx strobe, and read-byte bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         count_q       <= '0;
         payload_q     <= '0;
         rxData_q      <= '0;
         rxValid_q     <= 1'b0;
         rdAddrSeen_q  <= 1'b0;
         payloadDone_q <= 1'b0;
         loaded_q      <= 1'b0;
         txDone_q      <= 1'b0;
      end else begin
         rxValid_q <= 1'b0;
         if (state_q != IDLE && SS_n) begin
            state_q       <= IDLE;
            count_q       <= '0;
            payloadDone_q <= 1'b0;
            loaded_q      <= 1'b0;
            txDone_q      <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  count_q       <= '0;
                  payloadDone_q <= 1'b0;
                  loaded_q      <= 1'b0;
                  txDone_q      <= 1'b0;
                  if (!SS_n) begin
                     state_q <= CHK_CMD;
                  end
               end
               CHK_CMD: begin
                  count_q <= '0;
                  if (!MOSI) begin
                     state_q <= WRITE;
                  end else if (rdAddrSeen_q) begin
                     state_q <= READ_DATA;
                  end else begin
                     state_q <= READ_ADD;
                  end
               end
               default: begin
                  if (!payloadDone_q) begin
                     payload_q <= {payload_q[PW-3:0], MOSI};
                     if (count_q == 4'(PW - 1)) begin
                        rxData_q      <= {payload_q, MOSI};
                        rxValid_q     <= 1'b1;
                        payloadDone_q <= 1'b1;
                        count_q       <= '0;
                        if (state_q == READ_ADD) begin
                           rdAddrSeen_q <= 1'b1;
                        end
                     end else begin
                        count_q <= count_q + 4'd1;
                     end
                  end else if (state_q == READ_DATA) begin
                     if (loadEn) begin
                        loaded_q <= 1'b1;
                        count_q  <= '0;
                     end else if (shiftEn) begin
                        count_q <= count_q + 4'd1;
                        if (count_q == 4'(DATA_W - 1)) begin
                           txDone_q     <= 1'b1;
                           rdAddrSeen_q <= 1'b0;
                        end
                     end
                  end
               end
            endcase
         end
      end
   end

   spi_tx_shift #(
      .DATA_W(DATA_W)
   ) uTxShift (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .clear_i(SS_n),
      .load_i (loadEn),
      .shift_i(shiftEn),
      .data_i (tx_data),
      .miso_o (MISO)
   );

   assign rx_data  = rxData_q;
   assign rx_valid = rxValid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a scoreboard of expected rx words plus direct MISO and state checks.
module tb_spi_slave;
   import spi_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;

   int         checks;
   int         errors;
   logic       misoMustBeZero;
   logic [9:0] expRx[$];

   spi_slave #(
      .DATA_W(8)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .SS_n    (SS_n),
      .MOSI    (MOSI),
      .MISO    (MISO),
      .rx_data (rx_data),
      .rx_valid(rx_valid),
      .tx_data (tx_data),
      .tx_valid(tx_valid)
   );

   // 10-unit clock; the bench drives and samples on the falling edge
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: count it and report any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard consumer: every rx_valid pulse must match the oldest expected word; MISO idles low outside read windows
   always @(negedge clk) begin
      if (rx_valid) begin
         if (expRx.size() == 0) begin
            checkOutput("rx_unexpected", 32'(rx_valid), 32'd0);
         end else begin
            checkOutput("rx_data", 32'(rx_data), 32'(expRx.pop_front()));
         end
      end
      if (misoMustBeZero) begin
         checkOutput("miso_idle", 32'(MISO), 32'd0);
      end
   end

   // One SS_n frame: selector, nBits payload bits (10 = complete, fewer = aborted), optional RAM read-byte return
   task automatic applyStimulus(input logic sel, input logic [9:0] payload, input int nBits,
                                input state_e expPath, input logic withRead, input logic [7:0] txByte,
                                input logic expSeen);
      logic [7:0] b;
      b = txByte;
      if (nBits == 10) begin
         expRx.push_back(payload);
      end
      @(negedge clk);
      SS_n = 1'b0;
      MOSI = 1'b0;
      @(negedge clk);
      MOSI = sel;
      for (int i = 0; i < nBits; i++) begin
         @(negedge clk);
         if (i == 0) begin
            checkOutput("path", 32'(dut.state_q), 32'(expPath));
         end
         MOSI = payload[9-i];
      end
      if (withRead) begin
         @(negedge clk);
         @(negedge clk);
         misoMustBeZero = 1'b0;
         tx_data  = b;
         tx_valid = 1'b1;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 4) begin
               tx_valid = 1'b0;
            end
            checkOutput("miso_bit", 32'(MISO), (i < 8) ? 32'(b[7-i]) : 32'd0);
         end
         misoMustBeZero = 1'b1;
      end else if (nBits == 10) begin
         repeat (2) @(negedge clk);
      end
      @(negedge clk);
      SS_n = 1'b1;
      MOSI = 1'b0;
      @(negedge clk);
      checkOutput("state_idle", 32'(dut.state_q), 32'(IDLE));
      checkOutput("rd_addr_seen", 32'(dut.rdAddrSeen_q), 32'(expSeen));
      checkOutput("rx_pending", 32'(expRx.size()), 32'd0);
   endtask

   // Test sequence
   initial begin
      checks         = 0;
      errors         = 0;
      misoMustBeZero = 1'b1;
      rst_n          = 1'b0;
      SS_n           = 1'b1;
      MOSI           = 1'b0;
      tx_data        = 8'h00;
      tx_valid       = 1'b0;

      repeat (2) @(negedge clk);
      checkOutput("rst_miso", 32'(MISO), 32'd0);
      checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
      checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
      checkOutput("rst_seen", 32'(dut.rdAddrSeen_q), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] write address frame");
      applyStimulus(1'b0, 10'b00_1010_0101, 10, WRITE, 1'b0, 8'h00, 1'b0);

      $display("[TB] read address frame");
      applyStimulus(1'b1, 10'b10_0000_0011, 10, READ_ADD, 1'b0, 8'h00, 1'b1);

      $display("[TB] aborted frame after 6 payload bits");
      applyStimulus(1'b0, 10'b01_1111_1111, 6, WRITE, 1'b0, 8'h00, 1'b1);

      $display("[TB] read data frame");
      applyStimulus(1'b1, 10'b11_0000_0000, 10, READ_DATA, 1'b1, 8'hC3, 1'b0);

      $display("[TB] reset mid-frame");
      @(negedge clk);
      SS_n = 1'b0;
      @(negedge clk);
      MOSI = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         MOSI = ~MOSI;
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_miso", 32'(MISO), 32'd0);
      checkOutput("midrst_rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("midrst_state", 32'(dut.state_q), 32'(IDLE));
      checkOutput("midrst_count", 32'(dut.count_q), 32'd0);
      @(negedge clk);
      SS_n = 1'b1;
      MOSI = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] read data without prior read address");
      applyStimulus(1'b1, 10'b11_0000_0000, 10, READ_ADD, 1'b0, 8'h00, 1'b1);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
